interval_minmax_stats: RTL
==========================

Name: interval_minmax_stats

Overview:
- Synthesisable successor to the per-interval min/max tracker in the audio sound-processing path.
- Tracks the running signed min/max of an audio stream over fixed-length or flushed intervals, and keeps a ring buffer of the last HIST_DEPTH interval results.
- Computes integer history means and a mean-absolute-deviation outlier flag for each new interval, using no real arithmetic, sqrt or divide.
- Sits after the sample source; its results feed downstream filtering/logging.

Parameters:
SAMPLE_W, 16, signed sample width
INTERVAL_LEN, 44100, accepted samples per interval; must be >= HIST_DEPTH+4
HIST_DEPTH, 8, history ring depth; power of two >= 2
DEV_MULT, 2, outlier threshold multiplier on mean absolute deviation

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous, active-low reset
audio_sample  input  SAMPLE_W  signed sample
sample_valid  input  1  sample qualifier
flush  input  1  close current interval early
result_valid  output  1  one-cycle result strobe
min_out  output  SAMPLE_W  signed interval minimum
max_out  output  SAMPLE_W  signed interval maximum
min_mean  output  SAMPLE_W  signed history mean of minima
max_mean  output  SAMPLE_W  signed history mean of maxima
min_outlier  output  1  minimum is an outlier
max_outlier  output  1  maximum is an outlier
stats_valid  output  1  history full at report time
hist_count  output  $clog2(HIST_DEPTH)+1  stored intervals, saturating
overrun  output  1  sticky: an interval was dropped

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs go to 0; FSM goes to IDLE.
  - Sample counter, history, sums, write pointer and overrun are cleared.
  - The in-progress interval and any pending result are discarded; reset during SCAN produces no result_valid.
- Collection:
  - Runs every cycle, independent of the FSM.
  - The first accepted sample of an interval loads run_min = run_max = sample; later samples update them by signed compare.
- Interval close:
  - Occurs on an accepted sample when count == INTERVAL_LEN-1, or when flush=1 with at least one sample in the interval.
  - flush together with sample_valid: the sample is included, then the interval closes.
  - flush with an empty interval is ignored.
  - On close, snapshot run_min/run_max and restart the counter at 0.
- FSM states: IDLE -> UPDATE -> MEAN -> SCAN -> REPORT -> IDLE.
  - IDLE -> UPDATE on close.
  - UPDATE (1 cycle): write the snapshot at wr_ptr, advance wr_ptr mod HIST_DEPTH. sum += new - evicted, where evicted is 0 until history is full. hist_count saturates at HIST_DEPTH.
  - MEAN (1 cycle): mean = sum >>> log2(HIST_DEPTH), arithmetic shift (floor toward -inf).
  - SCAN (HIST_DEPTH cycles): accumulate mad_sum += |x_i - mean| over all entries, separately for min and max.
  - REPORT (1 cycle): result_valid=1; all result outputs are registered and held until the next REPORT.
- Latency: result_valid asserts exactly HIST_DEPTH+3 cycles after the edge that closed the interval.
- Outlier rule: flag = (|x_new - mean| * HIST_DEPTH) > (mad_sum * DEV_MULT), strict greater-than, evaluated only when the history is full.
  - When not full: flags=0, stats_valid=0, means=0.
- Widths:
  - sum: SAMPLE_W + log2(HIST_DEPTH) signed.
  - deviation: SAMPLE_W+1 unsigned.
  - mad_sum: SAMPLE_W + 1 + log2(HIST_DEPTH).
  - Compare products are sized so they cannot overflow.
  - Mean fits SAMPLE_W by construction.
- Close while FSM is not IDLE (flush only):
  - overrun set sticky, cleared only by reset.
  - That interval's result is dropped, not queued.
  - Collection of the following interval proceeds normally.

Test Plan:
Bench parameters for all scenarios: SAMPLE_W=16, INTERVAL_LEN=8, HIST_DEPTH=4, DEV_MULT=2.
1. Reset: hold rst=0 for 3 cycles -> all outputs 0. Release, then feed 3,-5,7,0,2,-1,4,1 -> 7 cycles after the last sample's edge: result_valid one cycle, min_out=-5, max_out=7, hist_count=1, stats_valid=0, flags 0.
2. Mean and outlier on maxima: five intervals with maxima 10,12,10,12,40 and all minima -3 ->
   - 4th report: max_mean=11, max_outlier=0, stats_valid=1.
   - 5th report: max_mean=18, mad 42, 88>84 -> max_outlier=1.
   - min_mean=-3, min_outlier=0 throughout.
3. Negative floor: interval minima -1,-2,-2,-2 -> min_mean=-2 (sum -7 >>> 2).
4. Flush:
   - Samples 5,6,-9 then flush -> min_out=-9, max_out=6.
   - flush with no samples -> no result_valid.
   - flush with sample_valid and sample 20 -> 20 included in that interval.
5. Overrun: flush-close an interval, then accept 1 sample and flush 2 cycles later -> overrun=1, only one result_valid. The next full 8-sample interval reports normally.
6. Reset mid-operation: rst=0 during SCAN -> no result_valid, hist_count=0; the subsequent interval reports with hist_count=1.

Source files
------------

// File: rtl/interval_minmax_stats.sv
// Per-interval signed min/max tracker with a HIST_DEPTH-deep history ring, integer means and MAD outlier flags.
// Result strobes HIST_DEPTH+3 cycles after the closing edge; no backpressure, a close while busy is dropped and flagged.
module interval_minmax_stats #(
    parameter int SAMPLE_W     = 16,
    parameter int INTERVAL_LEN = 44100,
    parameter int HIST_DEPTH   = 8,
    parameter int DEV_MULT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [SAMPLE_W-1:0]    audio_sample,
    input  logic                          sample_valid,
    input  logic                          flush,
    output logic                          result_valid,
    output logic signed [SAMPLE_W-1:0]    min_out,
    output logic signed [SAMPLE_W-1:0]    max_out,
    output logic signed [SAMPLE_W-1:0]    min_mean,
    output logic signed [SAMPLE_W-1:0]    max_mean,
    output logic                          min_outlier,
    output logic                          max_outlier,
    output logic                          stats_valid,
    output logic [$clog2(HIST_DEPTH):0]   hist_count,
    output logic                          overrun
);
    localparam int L    = $clog2(HIST_DEPTH);
    localparam int CW   = $clog2(INTERVAL_LEN);
    localparam int SUMW = SAMPLE_W + L;
    localparam int DW   = SAMPLE_W + 1;
    localparam int MADW = SAMPLE_W + 1 + L;
    localparam int MW   = $clog2(DEV_MULT + 1);
    localparam int PW   = MADW + MW;
    localparam logic [PW-1:0] DM   = PW'(DEV_MULT);
    localparam logic [CW-1:0] LAST = CW'(INTERVAL_LEN - 1);
    localparam logic [L:0]    FULL = (L+1)'(HIST_DEPTH);

    typedef enum logic [2:0] {IDLE, UPDATE, MEAN, SCAN, REPORT} state_t;

    function automatic logic [DW-1:0] absdiff(input logic signed [SAMPLE_W-1:0] a,
                                              input logic signed [SAMPLE_W-1:0] b);
        logic signed [DW-1:0] d;
        d = DW'(a) - DW'(b);
        return d[DW-1] ? -d : d;
    endfunction

    state_t                      state, nxt;
    logic [CW-1:0]               count;
    logic signed [SAMPLE_W-1:0]  run_min, run_max, cur_min, cur_max;
    logic                        close;
    logic signed [SAMPLE_W-1:0]  snap_min, snap_max;
    logic signed [SAMPLE_W-1:0]  hist_min [HIST_DEPTH];
    logic signed [SAMPLE_W-1:0]  hist_max [HIST_DEPTH];
    logic [L-1:0]                wr_ptr, scan_idx;
    logic signed [SUMW-1:0]      sum_min, sum_max;
    logic signed [SAMPLE_W-1:0]  mean_min, mean_max, evict_min, evict_max;
    logic [MADW-1:0]             mad_min, mad_max;
    logic                        full, flag_min, flag_max;

    // Collection runs regardless of FSM state; the close sample is folded in before the snapshot.
    always_comb begin
        cur_min = run_min;
        cur_max = run_max;
        if (sample_valid) begin
            if (count == '0 || audio_sample < run_min) cur_min = audio_sample;
            if (count == '0 || audio_sample > run_max) cur_max = audio_sample;
        end
        close = (sample_valid && count == LAST) || (flush && (sample_valid || count != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= '0;
            run_min <= '0;
            run_max <= '0;
        end else begin
            if (sample_valid) begin
                run_min <= cur_min;
                run_max <= cur_max;
            end
            if (close)             count <= '0;
            else if (sample_valid) count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (close) nxt = UPDATE;
            UPDATE:  nxt = MEAN;
            MEAN:    nxt = SCAN;
            SCAN:    if (scan_idx == L'(HIST_DEPTH - 1)) nxt = REPORT;
            REPORT:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outlier compare: |x-mean|*HIST_DEPTH vs mad_sum*DEV_MULT, widened so neither side can wrap.
    always_comb begin
        full      = (hist_count == FULL);
        evict_min = full ? hist_min[wr_ptr] : '0;
        evict_max = full ? hist_max[wr_ptr] : '0;
        flag_min  = full && ((PW'(absdiff(snap_min, mean_min)) << L) > (PW'(mad_min) * DM));
        flag_max  = full && ((PW'(absdiff(snap_max, mean_max)) << L) > (PW'(mad_max) * DM));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_min     <= '0;
            snap_max     <= '0;
            wr_ptr       <= '0;
            scan_idx     <= '0;
            sum_min      <= '0;
            sum_max      <= '0;
            mean_min     <= '0;
            mean_max     <= '0;
            mad_min      <= '0;
            mad_max      <= '0;
            hist_count   <= '0;
            overrun      <= 1'b0;
            result_valid <= 1'b0;
            min_out      <= '0;
            max_out      <= '0;
            min_mean     <= '0;
            max_mean     <= '0;
            min_outlier  <= 1'b0;
            max_outlier  <= 1'b0;
            stats_valid  <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_min[i] <= '0;
                hist_max[i] <= '0;
            end
        end else begin
            result_valid <= (state == REPORT);
            if (close && state == IDLE) begin
                snap_min <= cur_min;
                snap_max <= cur_max;
            end
            if (close && state != IDLE) overrun <= 1'b1;
            case (state)
                UPDATE: begin
                    hist_min[wr_ptr] <= snap_min;
                    hist_max[wr_ptr] <= snap_max;
                    wr_ptr  <= wr_ptr + L'(1);
                    sum_min <= sum_min + SUMW'(snap_min) - SUMW'(evict_min);
                    sum_max <= sum_max + SUMW'(snap_max) - SUMW'(evict_max);
                    if (!full) hist_count <= hist_count + (L+1)'(1);
                end
                MEAN: begin
                    mean_min <= SAMPLE_W'(sum_min >>> L);
                    mean_max <= SAMPLE_W'(sum_max >>> L);
                    mad_min  <= '0;
                    mad_max  <= '0;
                    scan_idx <= '0;
                end
                SCAN: begin
                    mad_min  <= mad_min + MADW'(absdiff(hist_min[scan_idx], mean_min));
                    mad_max  <= mad_max + MADW'(absdiff(hist_max[scan_idx], mean_max));
                    scan_idx <= scan_idx + L'(1);
                end
                REPORT: begin
                    min_out     <= snap_min;
                    max_out     <= snap_max;
                    stats_valid <= full;
                    min_mean    <= full ? mean_min : '0;
                    max_mean    <= full ? mean_max : '0;
                    min_outlier <= flag_min;
                    max_outlier <= flag_max;
                end
                default: ;
            endcase
        end
    end
endmodule
